// File: rtl/fpga_reset_pkg.sv
// Shared types and default timing for the KC705 bring-up reset sequencer.
// State and cause encodings live here so the top and any debug logic agree on them.
package fpga_reset_pkg;

  typedef enum logic [2:0] {
    S_ASSERT,
    S_WAIT_LOCK,
    S_HOLD,
    S_PERIPH,
    S_RUN
  } rst_state_e;

  typedef enum logic [1:0] {
    CAUSE_POR    = 2'd0,
    CAUSE_BUTTON = 2'd1,
    CAUSE_LOCK   = 2'd2
  } rst_cause_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000;
  localparam int unsigned DEF_HOLD_CYCLES     = 256;
  localparam int unsigned DEF_STAGGER_CYCLES  = 16;
  localparam int unsigned DEF_CNT_W           = 16;

  // Debug press counter: sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/rst_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer for an asynchronous level.
// The accepted value only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
module rst_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_deb
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_meta;
  logic             r_sync;
  logic             r_deb;
  logic [CNT_W-1:0] r_cnt;

  // NOTE: every register here, synchroniser stages included, is cleared in reset so a
  // button that reads "pressed" (0) holds the sequencer in reset until it is proven released.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_deb  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      // NOTE: non-blocking assignments make r_sync take the old r_meta, giving two real stages.
      r_meta <= i_async;
      r_sync <= r_meta;
      if (r_sync == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == LP_LAST) begin
        r_deb <= r_sync;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_deb = r_deb;

endmodule

// File: rtl/fpga_reset_sequencer.sv
// Bring-up reset controller: waits for a debounced button release and clock lock, then
// releases the peripheral reset and, after a stagger, the SoC reset; aborts on press or lock loss.
module fpga_reset_sequencer
  import fpga_reset_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned STAGGER_CYCLES  = DEF_STAGGER_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       btn_rst_ni,
  input  logic       clk_locked_i,
  output logic       periph_rst_no,
  output logic       soc_rst_no,
  output logic       busy_o,
  output logic [1:0] cause_o,
  output logic [7:0] press_cnt_o
);

  localparam logic [CNT_W-1:0] LP_HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);

  logic             w_deb;
  logic             r_lock_meta;
  logic             r_lock_s;

  rst_state_e       r_state;
  rst_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_periph;
  logic             r_soc;
  logic             w_periph_nxt;
  logic             w_soc_nxt;
  rst_cause_e       r_cause;
  rst_cause_e       w_cause_nxt;
  logic [7:0]       r_press;
  logic [7:0]       w_press_nxt;
  logic             w_abort_btn;
  logic             w_abort_lock;

  rst_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_btn_debounce (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_async (btn_rst_ni),
    .o_deb   (w_deb)
  );

  // A press aborts from anywhere but S_ASSERT; lock loss only once the hold has started.
  assign w_abort_btn  = (r_state != S_ASSERT) && !w_deb;
  assign w_abort_lock = ((r_state == S_HOLD) || (r_state == S_PERIPH) || (r_state == S_RUN))
                        && !r_lock_s;

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cause_nxt = r_cause;
    w_press_nxt = r_press;

    case (r_state)
      S_ASSERT: begin
        w_cnt_nxt = '0;
        if (w_deb) w_state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        w_cnt_nxt = '0;
        if (r_lock_s) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (r_cnt == LP_HOLD_LAST) begin
          w_state_nxt = S_PERIPH;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_PERIPH: begin
        if (r_cnt == LP_STAGGER_LAST) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_RUN: begin
        w_cnt_nxt = '0;
      end
      default: begin
        w_state_nxt = S_ASSERT;
        w_cnt_nxt   = '0;
      end
    endcase

    // The button is checked first so a simultaneous press and lock loss is logged as a press.
    if (w_abort_btn) begin
      w_state_nxt = S_ASSERT;
      w_cnt_nxt   = '0;
      w_cause_nxt = CAUSE_BUTTON;
      w_press_nxt = sat_inc8(r_press);
    end else if (w_abort_lock) begin
      w_state_nxt = S_ASSERT;
      w_cnt_nxt   = '0;
      w_cause_nxt = CAUSE_LOCK;
    end

    w_periph_nxt = (w_state_nxt == S_PERIPH) || (w_state_nxt == S_RUN);
    w_soc_nxt    = (w_state_nxt == S_RUN);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
      r_state     <= S_ASSERT;
      r_cnt       <= '0;
      r_periph    <= 1'b0;
      r_soc       <= 1'b0;
      r_cause     <= CAUSE_POR;
      r_press     <= '0;
    end else begin
      r_lock_meta <= clk_locked_i;
      r_lock_s    <= r_lock_meta;
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_periph    <= w_periph_nxt;
      r_soc       <= w_soc_nxt;
      r_cause     <= w_cause_nxt;
      r_press     <= w_press_nxt;
    end
  end

  assign periph_rst_no = r_periph;
  assign soc_rst_no    = r_soc;
  assign busy_o        = ~r_soc;
  assign cause_o       = r_cause;
  assign press_cnt_o   = r_press;

endmodule

// File: tb/tb_fpga_reset_sequencer.sv
// Scoreboard bench for fpga_reset_sequencer: stimulus queues the output word and the cycle it
// must appear on; a negedge monitor pops an entry whenever the output word changes.
module tb_fpga_reset_sequencer;

  typedef struct {
    int          cyc;
    logic [12:0] val;
  } exp_t;

  logic       clk;
  logic       rst_ni;
  logic       btn_rst_ni;
  logic       clk_locked_i;
  logic       periph_rst_no;
  logic       soc_rst_no;
  logic       busy_o;
  logic [1:0] cause_o;
  logic [7:0] press_cnt_o;

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic        mon_en = 1'b0;
  logic [12:0] mon_prev;
  logic [12:0] w_tuple;
  logic [7:0]  exp_press;

  fpga_reset_sequencer #(
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (8),
    .STAGGER_CYCLES  (4),
    .CNT_W           (16)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .btn_rst_ni    (btn_rst_ni),
    .clk_locked_i  (clk_locked_i),
    .periph_rst_no (periph_rst_no),
    .soc_rst_no    (soc_rst_no),
    .busy_o        (busy_o),
    .cause_o       (cause_o),
    .press_cnt_o   (press_cnt_o)
  );

  assign w_tuple = {periph_rst_no, soc_rst_no, busy_o, cause_o, press_cnt_o};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Output word: periph, soc, busy (always the inverse of soc), cause, press count.
  function automatic logic [12:0] mk(input logic p, input logic s, input logic [1:0] c,
                                     input logic [7:0] n);
    return {p, s, ~s, c, n};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, got, exp);
    end
  endtask

  task automatic push(input int at, input logic p, input logic s, input logic [1:0] c,
                      input logic [7:0] n);
    exp_q.push_back('{cyc: at, val: mk(p, s, c, n)});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en && (w_tuple !== mon_prev)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_change at cycle %0d: got 0x%0h, expected no change from 0x%0h",
                 cyc, w_tuple, mon_prev);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_word", 32'(w_tuple), 32'(mon_e.val));
        check("out_cycle", cyc, mon_e.cyc);
      end
      mon_prev = w_tuple;
    end
  end

  initial begin
    int c;
    rst_ni       = 1'b0;
    btn_rst_ni   = 1'b1;
    clk_locked_i = 1'b1;
    tick(3);
    check("por_state", 32'(w_tuple), 32'(mk(1'b0, 1'b0, 2'd0, 8'd0)));
    mon_prev = mk(1'b0, 1'b0, 2'd0, 8'd0);
    mon_en   = 1'b1;

    // POR release: deb=1 at +6, WAIT_LOCK +7, HOLD +8, PERIPH +16, RUN +20.
    c = cyc;
    rst_ni = 1'b1;
    push(c + 16, 1'b1, 1'b0, 2'd0, 8'd0);
    push(c + 20, 1'b1, 1'b1, 2'd0, 8'd0);
    tick(24);

    // Three-cycle glitch is one short of the debounce window: nothing may change.
    btn_rst_ni = 1'b0;
    tick(3);
    btn_rst_ni = 1'b1;
    tick(12);
    check("glitch_soc", 32'(soc_rst_no), 32'd1);
    check("glitch_press", 32'(press_cnt_o), 32'd0);

    // Long press in RUN: abort at +7, release at +10, deb=1 at +16, HOLD +18.
    c = cyc;
    btn_rst_ni = 1'b0;
    push(c + 7, 1'b0, 1'b0, 2'd1, 8'd1);
    tick(10);
    btn_rst_ni = 1'b1;
    push(c + 26, 1'b1, 1'b0, 2'd1, 8'd1);
    push(c + 30, 1'b1, 1'b1, 2'd1, 8'd1);
    tick(24);

    // Lock loss in RUN, then again in PERIPH; each return needs a full 8-cycle hold.
    c = cyc;
    clk_locked_i = 1'b0;
    push(c + 3, 1'b0, 1'b0, 2'd2, 8'd1);
    tick(10);
    clk_locked_i = 1'b1;
    push(c + 21, 1'b1, 1'b0, 2'd2, 8'd1);
    tick(11);
    clk_locked_i = 1'b0;
    push(c + 24, 1'b0, 1'b0, 2'd2, 8'd1);
    tick(9);
    clk_locked_i = 1'b1;
    push(c + 41, 1'b1, 1'b0, 2'd2, 8'd1);
    push(c + 45, 1'b1, 1'b1, 2'd2, 8'd1);
    tick(20);

    // Press and lock loss seen on the same edge (+7): the button is the recorded cause.
    c = cyc;
    btn_rst_ni = 1'b0;
    tick(4);
    clk_locked_i = 1'b0;
    push(c + 7, 1'b0, 1'b0, 2'd1, 8'd2);
    tick(6);
    btn_rst_ni   = 1'b1;
    clk_locked_i = 1'b1;
    push(c + 26, 1'b1, 1'b0, 2'd1, 8'd2);
    push(c + 30, 1'b1, 1'b1, 2'd1, 8'd2);
    tick(24);

    // Park in WAIT_LOCK with lock low, then 300 presses; the count must stick at 255.
    c = cyc;
    clk_locked_i = 1'b0;
    push(c + 3, 1'b0, 1'b0, 2'd2, 8'd2);
    tick(8);
    exp_press = 8'd2;
    for (int i = 0; i < 300; i++) begin
      c = cyc;
      btn_rst_ni = 1'b0;
      if (exp_press != 8'd255) begin
        exp_press = exp_press + 8'd1;
        push(c + 7, 1'b0, 1'b0, 2'd1, exp_press);
      end
      tick(8);
      btn_rst_ni = 1'b1;
      tick(8);
    end
    check("press_sat", 32'(press_cnt_o), 32'd255);
    check("press_cause", 32'(cause_o), 32'd1);

    // rst_ni pulse during HOLD (entered at +3): reset values on +6, then a POR-like restart.
    c = cyc;
    clk_locked_i = 1'b1;
    tick(5);
    rst_ni = 1'b0;
    push(c + 6, 1'b0, 1'b0, 2'd0, 8'd0);
    tick(1);
    rst_ni = 1'b1;
    push(c + 22, 1'b1, 1'b0, 2'd0, 8'd0);
    push(c + 26, 1'b1, 1'b1, 2'd0, 8'd0);
    tick(30);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick(1);
    check("exp_pending", exp_q.size(), 0);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
